// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath constants and the AddRoundKey sequencer states
package aes_pkg;
    localparam int AES_WORD_W = 32;
    localparam int AES_NB = 4;
    typedef enum logic {S_KEY, S_DATA} ark_state_t;
endpackage

// File: rtl/add_round_key_seq_if.sv
// add_round_key_seq_if: key, state-in and state-out valid/ready channels of the AddRoundKey engine
interface add_round_key_seq_if #(parameter int WORD_W = aes_pkg::AES_WORD_W);
    logic              key_valid, key_ready, key_hold;
    logic              in_valid, in_ready;
    logic              out_valid, out_ready, out_last;
    logic [WORD_W-1:0] key_word, state_in, state_out;
    modport master (
        output key_valid, key_word, key_hold, in_valid, state_in, out_ready,
        input  key_ready, in_ready, out_valid, state_out, out_last
    );
    modport slave (
        input  key_valid, key_word, key_hold, in_valid, state_in, out_ready,
        output key_ready, in_ready, out_valid, state_out, out_last
    );
endinterface

// File: rtl/ark_key_buf.sv
// ark_key_buf: NB-entry round-key register file with one write port and one combinational read port
module ark_key_buf #(
    parameter int WORD_W = 32,
    parameter int NB = 4,
    parameter int CNT_W = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [CNT_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o
);
    logic [WORD_W-1:0] mem_q [NB];
    always_ff @(posedge clk or posedge rst)
        if (rst) mem_q <= '{default: '0};
        else if (we_i) mem_q[wr_idx_i] <= wr_data_i;
    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/add_round_key_seq.sv
// add_round_key_seq: buffers a round key word by word, then XORs streamed state words with it through one register stage
module add_round_key_seq
    import aes_pkg::*;
#(
    parameter int WORD_W = AES_WORD_W,
    parameter int NB = AES_NB
) (
    input logic clk,
    input logic rst,
    add_round_key_seq_if.slave bus
);
    localparam int CNT_W = $clog2(NB);
    ark_state_t        state_q, state_d;
    logic [CNT_W-1:0]  key_idx_q, key_idx_d, col_q, col_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [WORD_W-1:0] state_out_q, state_out_d, key_rd;
    logic              key_ready, in_ready, key_hs, in_hs, out_hs, key_last, col_last;
    assign key_ready = state_q == S_KEY;
    assign in_ready  = state_q == S_DATA && (!out_valid_q || bus.out_ready);
    assign key_hs    = bus.key_valid && key_ready;
    assign in_hs     = bus.in_valid && in_ready;
    assign out_hs    = out_valid_q && bus.out_ready;
    assign key_last  = key_idx_q == CNT_W'(NB - 1);
    assign col_last  = col_q == CNT_W'(NB - 1);
    ark_key_buf #(.WORD_W(WORD_W), .NB(NB), .CNT_W(CNT_W)) u_key_buf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (key_hs),
        .wr_idx_i (key_idx_q),
        .wr_data_i(bus.key_word),
        .rd_idx_i (col_q),
        .rd_data_o(key_rd)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= S_KEY;
            key_idx_q   <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            key_idx_q   <= key_idx_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            state_out_q <= state_out_d;
        end
    // Counters wrap explicitly at NB-1 so non-power-of-2 NB never reaches an unused index
    always_comb begin
        key_idx_d   = key_hs ? (key_last ? '0 : key_idx_q + 1'b1) : key_idx_q;
        col_d       = in_hs ? (col_last ? '0 : col_q + 1'b1) : col_q;
        state_d     = (key_hs && key_last) ? S_DATA :
                      (in_hs && col_last && !bus.key_hold) ? S_KEY : state_q;
        out_valid_d = in_hs ? 1'b1 : out_hs ? 1'b0 : out_valid_q;
        out_last_d  = in_hs ? col_last : out_last_q;
        state_out_d = in_hs ? bus.state_in ^ key_rd : state_out_q;
    end
    assign bus.key_ready = key_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.state_out = state_out_q;
endmodule

// File: tb/tb_add_round_key_seq.sv
// tb_add_round_key_seq: random and FIPS-197 stimulus against a per-column XOR reference for NB=4 and NB=3 engines
module tb_add_round_key_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    add_round_key_seq_if #(.WORD_W(32)) b ();
    add_round_key_seq_if #(.WORD_W(8))  b3 ();
    add_round_key_seq #(.WORD_W(32), .NB(4)) dut  (.clk(clk), .rst(rst), .bus(b.slave));
    add_round_key_seq #(.WORD_W(8),  .NB(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
    int errs = 0;
    int checks = 0;
    logic [31:0] key_m [4];
    logic [7:0]  key3_m [3];
    logic [32:0] got_q [$];
    logic [8:0]  got3_q [$];
    always @(posedge clk) if (!rst && b.out_valid && b.out_ready) got_q.push_back({b.out_last, b.state_out});
    always @(posedge clk) if (!rst && b3.out_valid && b3.out_ready) got3_q.push_back({b3.out_last, b3.state_out});

    task automatic load_key4;
        foreach (key_m[i]) begin
            @(negedge clk);
            b.in_valid = 1'b0; b.key_valid = 1'b1; b.key_word = key_m[i];
        end
        @(negedge clk);
        b.key_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({b.key_ready, b.in_ready, b.out_valid, b.out_last, b.state_out} !== {4'b1000, 32'h0}) begin
            errs++; $display("FAIL reset4 got=%b_%h exp=1000_00000000", {b.key_ready, b.in_ready, b.out_valid, b.out_last}, b.state_out);
        end
        checks++;
        if ({b3.key_ready, b3.in_ready, b3.out_valid, b3.out_last, b3.state_out} !== {4'b1000, 8'h0}) begin
            errs++; $display("FAIL reset3 got=%b_%h exp=1000_00", {b3.key_ready, b3.in_ready, b3.out_valid, b3.out_last}, b3.state_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_fips;
        logic [31:0] s [4];
        logic [31:0] e [4];
        key_m = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
        s = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
        e = '{32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808};
        b.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b.in_ready !== 1'b0 || b.key_ready !== 1'b1) begin
            errs++; $display("FAIL fips_idle in_ready=%b key_ready=%b exp 0/1", b.in_ready, b.key_ready);
        end
        load_key4();
        checks++;
        if (b.in_ready !== 1'b1) begin errs++; $display("FAIL fips_first_in_ready got=%b exp=1", b.in_ready); end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                checks++;
                if (b.out_valid !== 1'b0) begin errs++; $display("FAIL fips_no_early_out got=%b exp=0", b.out_valid); end
            end else begin
                checks++;
                if (b.out_valid !== 1'b1 || b.state_out !== e[i-1] || b.out_last !== (i == 4)) begin
                    errs++; $display("FAIL fips_word%0d got=%b/%h/%b exp=1/%h/%b", i - 1, b.out_valid, b.state_out, b.out_last, e[i-1], i == 4);
                end
            end
            b.in_valid = i < 4; b.state_in = s[i%4]; b.key_hold = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (b.out_valid !== 1'b0 || b.key_ready !== 1'b1) begin
            errs++; $display("FAIL fips_end out_valid=%b key_ready=%b exp 0/1", b.out_valid, b.key_ready);
        end
    endtask

    task automatic test_key_hold;
        logic [32:0] exp_q [$];
        logic [31:0] w;
        got_q.delete();
        foreach (key_m[i]) key_m[i] = $urandom;
        b.out_ready = 1'b1;
        load_key4();
        for (int blk = 0; blk < 2; blk++)
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checks++;
                if (b.key_ready !== 1'b0) begin errs++; $display("FAIL hold_key_ready blk%0d col%0d got=%b exp=0", blk, i, b.key_ready); end
                w = blk == 0 ? $urandom : 32'h0;
                b.in_valid = 1'b1; b.state_in = w; b.key_hold = blk == 0;
                exp_q.push_back({i == 3, w ^ key_m[i]});
            end
        @(negedge clk);
        b.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL hold_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL hold_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] w [8];
        logic [32:0] exp_q [$];
        got_q.delete();
        foreach (key_m[i]) key_m[i] = $urandom;
        foreach (w[i]) begin
            w[i] = $urandom;
            exp_q.push_back({i % 4 == 3, w[i] ^ key_m[i%4]});
        end
        b.out_ready = 1'b1;
        load_key4();
        @(negedge clk);
        b.in_valid = 1'b1; b.state_in = w[0]; b.key_hold = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0; b.state_in = w[1];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (b.out_valid !== 1'b1 || b.state_out !== exp_q[0][31:0] || b.in_ready !== 1'b0) begin
                errs++; $display("FAIL stall%0d got=%b/%h/%b exp=1/%h/0", c, b.out_valid, b.state_out, b.in_ready, exp_q[0][31:0]);
            end
        end
        b.out_ready = 1'b1;
        for (int j = 2; j <= 8; j++) begin
            @(negedge clk);
            checks++;
            if (b.out_valid !== 1'b1 || b.state_out !== exp_q[j-1][31:0]) begin
                errs++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", j - 1, b.out_valid, b.state_out, exp_q[j-1][31:0]);
            end
            b.in_valid = j < 8;
            if (j < 8) begin b.state_in = w[j]; b.key_hold = j < 4; end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_key_in_data;
        logic [32:0] exp_q [$];
        logic [31:0] w;
        got_q.delete();
        foreach (key_m[i]) key_m[i] = $urandom;
        b.out_ready = 1'b1;
        load_key4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b.key_ready !== 1'b0) begin errs++; $display("FAIL kid_key_ready col%0d got=%b exp=0", i, b.key_ready); end
            w = $urandom;
            b.key_valid = 1'b1; b.key_word = 32'hffffffff;
            b.in_valid = 1'b1; b.state_in = w; b.key_hold = 1'b0;
            exp_q.push_back({i == 3, w ^ key_m[i]});
        end
        foreach (key_m[i]) key_m[i] = 32'hffffffff;
        load_key4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w = $urandom;
            b.in_valid = 1'b1; b.state_in = w; b.key_hold = 1'b0;
            exp_q.push_back({i == 3, ~w});
        end
        @(negedge clk);
        b.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL kid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL kid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_key;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b.key_valid = 1'b1; b.key_word = 32'hdeadbeef + i;
        end
        @(negedge clk);
        b.key_valid = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if ({b.out_valid, b.key_ready, b.in_ready} !== 3'b010 || b.state_out !== 32'h0) begin
            errs++; $display("FAIL rst_key got=%b/%h exp=010/00000000", {b.out_valid, b.key_ready, b.in_ready}, b.state_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_data;
        foreach (key_m[i]) key_m[i] = $urandom;
        b.out_ready = 1'b1;
        load_key4();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b.in_valid = 1'b1; b.state_in = $urandom | 32'h1; b.key_hold = 1'b0;
        end
        @(negedge clk);
        b.in_valid = 1'b0;
        checks++;
        if (b.out_valid !== 1'b1) begin errs++; $display("FAIL rst_data_pending got=%b exp=1", b.out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if ({b.out_valid, b.key_ready, b.in_ready} !== 3'b010 || b.state_out !== 32'h0) begin
            errs++; $display("FAIL rst_data got=%b/%h exp=010/00000000", {b.out_valid, b.key_ready, b.in_ready}, b.state_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nb3;
        logic [8:0] exp_q [$];
        logic [7:0] w;
        logic hold, need;
        need = 1'b1;
        got3_q.delete();
        b3.out_ready = 1'b1;
        for (int blk = 0; blk < 6; blk++) begin
            if (need) begin
                foreach (key3_m[i]) begin
                    @(negedge clk);
                    key3_m[i] = 8'($urandom);
                    b3.in_valid = 1'b0; b3.key_valid = 1'b1; b3.key_word = key3_m[i];
                end
                @(negedge clk);
                b3.key_valid = 1'b0;
            end
            hold = blk < 5 ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                w = 8'($urandom);
                b3.in_valid = 1'b1; b3.state_in = w; b3.key_hold = hold;
                exp_q.push_back({i == 2, w ^ key3_m[i]});
            end
            need = !hold;
        end
        @(negedge clk);
        b3.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got3_q.size() != exp_q.size()) begin errs++; $display("FAIL nb3_count got=%0d exp=%0d", got3_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got3_q.size(); i++) begin
            checks++;
            if (got3_q[i] !== exp_q[i]) begin errs++; $display("FAIL nb3_word%0d got=%h exp=%h", i, got3_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        {b.key_valid, b.key_hold, b.in_valid, b.out_ready} = '0;
        b.key_word = '0; b.state_in = '0;
        {b3.key_valid, b3.key_hold, b3.in_valid, b3.out_ready} = '0;
        b3.key_word = '0; b3.state_in = '0;
        test_reset();
        test_fips();
        test_key_hold();
        test_backpressure();
        test_key_in_data();
        test_reset_mid_key();
        test_fips();
        test_reset_mid_data();
        test_fips();
        test_nb3();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
